conv2_pe_column_sched: RTL and testbench

- Sequencer for one conv2 PE column: three chained 3-stage PE units, each with a 12-bit filter row and an 8-bit ifmap row input, and a single 14-bit Psum output.
- Loads the K filter rows once, then streams ifmap columns for each output row and gates the column enable.
- Tags every valid Psum with its (row, col) output coordinate and honours output backpressure.
- Sits between the ifmap/weight buffers and the PE column. One instance per column.

---
 rtl/conv2_pe_column_sched.sv | 184 ++++++++++++++++++
 tb/tb_conv2_pe_column_sched.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2_pe_column_sched.sv
// Sequencer for one conv2 PE column: loads K filter rows, then streams ifmap
// columns row by row and tags each finished Psum with its output coordinate.
module conv2_pe_column_sched #(
  parameter int IF_W   = 14,
  parameter int IF_H   = 14,
  parameter int K      = 3,
  parameter int RD_LAT = 1,
  parameter int PE_LAT = 3,
  localparam int OUT_W = IF_W - K + 1,
  localparam int OUT_H = IF_H - K + 1,
  localparam int KA_W  = (K > 1) ? $clog2(K) : 1,
  localparam int IR_W  = (IF_H > 1) ? $clog2(IF_H) : 1,
  localparam int IC_W  = (IF_W > 1) ? $clog2(IF_W) : 1,
  localparam int OR_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1,
  localparam int OC_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            w_rd_en,
  output logic [KA_W-1:0] w_rd_addr,
  output logic [K-1:0]    filtr_ld,
  output logic            if_rd_en,
  output logic [IR_W-1:0] if_rd_row,
  output logic [IC_W-1:0] if_rd_col,
  output logic            pe_en,
  input  logic            out_ready,
  output logic            psum_valid,
  output logic [OR_W-1:0] psum_row,
  output logic [OC_W-1:0] psum_col
);

  localparam int D    = RD_LAT + PE_LAT;
  localparam int LC_W = $clog2(K + RD_LAT + 1);
  localparam int DC_W = $clog2(D + 1);

  localparam logic [LC_W-1:0] LC_K    = LC_W'(K);
  localparam logic [LC_W-1:0] LC_LAST = LC_W'(K + RD_LAT - 1);
  localparam logic [IC_W-1:0] COL_OFF = IC_W'(K - 1);
  localparam logic [IC_W-1:0] COL_END = IC_W'(IF_W - 1);
  localparam logic [OR_W-1:0] ROW_END = OR_W'(OUT_H - 1);
  localparam logic [DC_W-1:0] DC_END  = DC_W'(D - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [LC_W-1:0]            lcnt_q, lcnt_d;
  logic [IC_W-1:0]            col_q, col_d;
  logic [OR_W-1:0]            row_q, row_d;
  logic [DC_W-1:0]            dcnt_q, dcnt_d;
  logic [RD_LAT-1:0][K-1:0]   ld_q, ld_d;
  logic [RD_LAT-1:0]          en_q, en_d;
  logic [D-1:0]               tv_q, tv_d;
  logic [D-1:0][OR_W-1:0]     tr_q, tr_d;
  logic [D-1:0][OC_W-1:0]     tc_q, tc_d;

  logic adv;
  logic rd;
  logic tag_v;

  always_comb begin
    // Everything downstream of the buffers freezes while an unaccepted Psum sits at the head.
    adv   = ~(tv_q[D-1] & ~out_ready);
    rd    = (state_q == S_STREAM) && adv;
    tag_v = rd && (col_q >= COL_OFF);

    busy       = (state_q == S_LOAD_W) || (state_q == S_STREAM) || (state_q == S_DRAIN);
    done       = (state_q == S_DONE);
    w_rd_en    = (state_q == S_LOAD_W) && (lcnt_q < LC_K);
    w_rd_addr  = w_rd_en ? KA_W'(lcnt_q) : '0;
    filtr_ld   = ld_q[RD_LAT-1];
    if_rd_en   = rd;
    if_rd_row  = rd ? IR_W'(row_q) : '0;
    if_rd_col  = rd ? col_q : '0;
    pe_en      = en_q[RD_LAT-1] & adv;
    psum_valid = tv_q[D-1];
    psum_row   = tr_q[D-1];
    psum_col   = tc_q[D-1];

    state_d = state_q;
    lcnt_d  = lcnt_q;
    col_d   = col_q;
    row_d   = row_q;
    dcnt_d  = dcnt_q;
    ld_d    = ld_q;
    en_d    = en_q;
    tv_d    = tv_q;
    tr_d    = tr_q;
    tc_d    = tc_q;

    ld_d[0] = w_rd_en ? (K'(1) << lcnt_q) : '0;
    for (int i = 1; i < RD_LAT; i++) ld_d[i] = ld_q[i-1];

    if (adv) begin
      en_d[0] = rd;
      for (int i = 1; i < RD_LAT; i++) en_d[i] = en_q[i-1];
      tv_d[0] = tag_v;
      tr_d[0] = tag_v ? row_q : '0;
      tc_d[0] = tag_v ? OC_W'(col_q - COL_OFF) : '0;
      for (int i = 1; i < D; i++) begin
        tv_d[i] = tv_q[i-1];
        tr_d[i] = tr_q[i-1];
        tc_d[i] = tc_q[i-1];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_W;
          lcnt_d  = '0;
          col_d   = '0;
          row_d   = '0;
          dcnt_d  = '0;
        end
      end
      S_LOAD_W: begin
        if (lcnt_q == LC_LAST) begin
          state_d = S_STREAM;
          col_d   = '0;
        end else begin
          lcnt_d = lcnt_q + 1'b1;
        end
      end
      S_STREAM: begin
        if (adv) begin
          if (col_q == COL_END) begin
            state_d = S_DRAIN;
            dcnt_d  = '0;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // D advancing cycles push the last column's tag out of the head.
        if (adv) begin
          if (dcnt_q == DC_END) begin
            if (row_q == ROW_END) begin
              state_d = S_DONE;
            end else begin
              state_d = S_STREAM;
              row_d   = row_q + 1'b1;
              col_d   = '0;
            end
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lcnt_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      dcnt_q  <= '0;
      ld_q    <= '0;
      en_q    <= '0;
      tv_q    <= '0;
      tr_q    <= '0;
      tc_q    <= '0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      dcnt_q  <= dcnt_d;
      ld_q    <= ld_d;
      en_q    <= en_d;
      tv_q    <= tv_d;
      tr_q    <= tr_d;
      tc_q    <= tc_d;
    end
  end

endmodule

// File: tb/tb_conv2_pe_column_sched.sv
// Directed bench for conv2_pe_column_sched with a 5x4 ifmap and K=3,
// giving a 3x2 output map (6 Psums per run).
module tb_conv2_pe_column_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       w_rd_en;
  logic [1:0] w_rd_addr;
  logic [2:0] filtr_ld;
  logic       if_rd_en;
  logic [1:0] if_rd_row;
  logic [2:0] if_rd_col;
  logic       pe_en;
  logic       out_ready;
  logic       psum_valid;
  logic [0:0] psum_row;
  logic [1:0] psum_col;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int beat_r[$];
  int beat_c[$];
  int beat_t[$];
  int ndone;
  int done_cyc;

  int exp_r[6]  = '{0, 0, 0, 1, 1, 1};
  int exp_c[6]  = '{0, 1, 2, 0, 1, 2};
  int exp_t[6]  = '{11, 12, 13, 20, 21, 22};
  int bp_t[6]   = '{11, 16, 17, 24, 25, 26};
  logic [6:0] load_exp[4] = '{7'b1_1_00_000, 7'b1_1_01_001, 7'b1_1_10_010, 7'b1_0_00_100};

  wire [18:0] outs = {busy, done, w_rd_en, w_rd_addr, filtr_ld, if_rd_en, if_rd_row,
                      if_rd_col, pe_en, psum_valid, psum_row, psum_col};

  conv2_pe_column_sched #(
    .IF_W(5), .IF_H(4), .K(3), .RD_LAT(1), .PE_LAT(3)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .filtr_ld(filtr_ld),
    .if_rd_en(if_rd_en), .if_rd_row(if_rd_row), .if_rd_col(if_rd_col),
    .pe_en(pe_en), .out_ready(out_ready), .psum_valid(psum_valid),
    .psum_row(psum_row), .psum_col(psum_col)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Runs until done (plus a few cycles), logging accepted beats; optionally
  // holds out_ready low for stall_len cycles once (0,1) reaches the head.
  task automatic collect(input int budget, input int stall_len);
    int  post;
    bit  stalled;
    beat_r.delete(); beat_c.delete(); beat_t.delete();
    ndone = 0; done_cyc = -1; post = 0; stalled = 0;
    for (int n = 0; n < budget; n++) begin
      step();
      if (stall_len > 0 && !stalled && psum_valid === 1'b1 && psum_row === 1'b0 && psum_col === 2'd1) begin
        stalled   = 1;
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          if (s > 0) step();
          #1;
          total++;
          if ({psum_valid, psum_row, psum_col} !== 4'b1_0_01) begin
            bad++;
            $display("[TB] FAIL stall_hold cyc=%0d got v=%b row=%0d col=%0d want v=1 row=0 col=1",
                     cyc, psum_valid, psum_row, psum_col);
          end
          total++;
          if ({pe_en, if_rd_en} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL stall_quiet cyc=%0d got pe_en=%b if_rd_en=%b want 0 0", cyc, pe_en, if_rd_en);
          end
        end
        step();
        out_ready = 1'b1;
        #1;
      end
      if (psum_valid === 1'b1 && out_ready === 1'b1) begin
        beat_r.push_back(int'(psum_row));
        beat_c.push_back(int'(psum_col));
        beat_t.push_back(cyc);
      end
      if (done === 1'b1) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("[TB] FAIL busy_with_done cyc=%0d got busy=%b want 0", cyc, busy);
        end
      end
      if (ndone > 0) begin
        post++;
        if (post > 3) break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    #12;
    total++;
    if (outs !== 19'd0) begin
      bad++;
      $display("[TB] FAIL reset_outputs got %h want 0", outs);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if (outs !== 19'd0) begin
        bad++;
        $display("[TB] FAIL idle_outputs cyc=%0d got %h want 0", i, outs);
      end
    end
  endtask

  task automatic test_load_and_run();
    cyc = 0;
    start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      start = 1'b0;
      total++;
      if ({busy, w_rd_en, w_rd_addr, filtr_ld} !== load_exp[i-1]) begin
        bad++;
        $display("[TB] FAIL load_cyc%0d got busy/rd/addr/ld=%b want %b", i,
                 {busy, w_rd_en, w_rd_addr, filtr_ld}, load_exp[i-1]);
      end
    end
    step();
    total++;
    if ({if_rd_en, if_rd_row, if_rd_col, pe_en} !== 7'b1_00_000_0) begin
      bad++;
      $display("[TB] FAIL first_read got rd=%b row=%0d col=%0d pe_en=%b want 1 0 0 0",
               if_rd_en, if_rd_row, if_rd_col, pe_en);
    end
    step();
    total++;
    if ({if_rd_en, if_rd_col, pe_en} !== 5'b1_001_1) begin
      bad++;
      $display("[TB] FAIL second_read got rd=%b col=%0d pe_en=%b want 1 1 1", if_rd_en, if_rd_col, pe_en);
    end
    collect(60, 0);
    total++;
    if (beat_r.size() != 6) begin
      bad++;
      $display("[TB] FAIL run_beat_count got %0d want 6", beat_r.size());
    end
    for (int i = 0; i < 6 && i < beat_r.size(); i++) begin
      total++;
      if (beat_r[i] != exp_r[i] || beat_c[i] != exp_c[i] || beat_t[i] != exp_t[i]) begin
        bad++;
        $display("[TB] FAIL run_beat%0d got (%0d,%0d)@%0d want (%0d,%0d)@%0d", i,
                 beat_r[i], beat_c[i], beat_t[i], exp_r[i], exp_c[i], exp_t[i]);
      end
    end
    total++;
    if (ndone != 1 || done_cyc != 23) begin
      bad++;
      $display("[TB] FAIL run_done got count=%0d cyc=%0d want count=1 cyc=23", ndone, done_cyc);
    end
  endtask

  task automatic test_backpressure();
    cyc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    collect(80, 4);
    total++;
    if (beat_r.size() != 6) begin
      bad++;
      $display("[TB] FAIL bp_beat_count got %0d want 6", beat_r.size());
    end
    for (int i = 0; i < 6 && i < beat_r.size(); i++) begin
      total++;
      if (beat_r[i] != exp_r[i] || beat_c[i] != exp_c[i] || beat_t[i] != bp_t[i]) begin
        bad++;
        $display("[TB] FAIL bp_beat%0d got (%0d,%0d)@%0d want (%0d,%0d)@%0d", i,
                 beat_r[i], beat_c[i], beat_t[i], exp_r[i], exp_c[i], bp_t[i]);
      end
    end
    total++;
    if (ndone != 1 || done_cyc != 27) begin
      bad++;
      $display("[TB] FAIL bp_done got count=%0d cyc=%0d want count=1 cyc=27", ndone, done_cyc);
    end
  endtask

  task automatic test_reset_mid_run();
    bit found;
    cyc = 0;
    found = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (if_rd_en === 1'b1 && if_rd_row === 2'd1) found = 1;
    end
    total++;
    if (!found || cyc != 14) begin
      bad++;
      $display("[TB] FAIL row1_reached got found=%0d cyc=%0d want 1 14", found, cyc);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (outs !== 19'd0) begin
      bad++;
      $display("[TB] FAIL async_reset got %h want 0", outs);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (outs !== 19'd0) begin
        bad++;
        $display("[TB] FAIL after_abort cyc=%0d got %h want 0", i, outs);
      end
    end
    cyc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    collect(60, 0);
    total++;
    if (beat_r.size() != 6) begin
      bad++;
      $display("[TB] FAIL rerun_beat_count got %0d want 6", beat_r.size());
    end
    for (int i = 0; i < 6 && i < beat_r.size(); i++) begin
      total++;
      if (beat_r[i] != exp_r[i] || beat_c[i] != exp_c[i] || beat_t[i] != exp_t[i]) begin
        bad++;
        $display("[TB] FAIL rerun_beat%0d got (%0d,%0d)@%0d want (%0d,%0d)@%0d", i,
                 beat_r[i], beat_c[i], beat_t[i], exp_r[i], exp_c[i], exp_t[i]);
      end
    end
    total++;
    if (ndone != 1 || done_cyc != 23) begin
      bad++;
      $display("[TB] FAIL rerun_done got count=%0d cyc=%0d want count=1 cyc=23", ndone, done_cyc);
    end
  endtask

  task automatic test_start_while_busy();
    cyc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < 8) step();
    start = 1'b1;
    step();
    start = 1'b0;
    collect(60, 0);
    total++;
    if (beat_r.size() != 6) begin
      bad++;
      $display("[TB] FAIL busy_start_beat_count got %0d want 6", beat_r.size());
    end
    for (int i = 0; i < 6 && i < beat_r.size(); i++) begin
      total++;
      if (beat_r[i] != exp_r[i] || beat_c[i] != exp_c[i] || beat_t[i] != exp_t[i]) begin
        bad++;
        $display("[TB] FAIL busy_start_beat%0d got (%0d,%0d)@%0d want (%0d,%0d)@%0d", i,
                 beat_r[i], beat_c[i], beat_t[i], exp_r[i], exp_c[i], exp_t[i]);
      end
    end
    total++;
    if (ndone != 1 || done_cyc != 23) begin
      bad++;
      $display("[TB] FAIL busy_start_done got count=%0d cyc=%0d want count=1 cyc=23", ndone, done_cyc);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL busy_start_idle got busy=%b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_load_and_run();
    test_backpressure();
    test_reset_mid_run();
    test_start_while_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

endmodule
